// File: rtl/ram_responder.sv
// Word-addressed RAM responder with programmable wait states and a free/busy/access/error
// status. Requesters hold a level request until the single ACCESS cycle.
module ram_responder #(
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // ramstate encoding
  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  // FSM state encoding
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam logic [3:0] LAT_M1 = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

  logic [0:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [29:0]   addr_q, addr_d;
  logic          op_q, op_d;  // 1 = write

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] word_idx;

  logic req_any;
  logic req_both;
  logic aligned;
  logic in_range;
  logic req_valid;
  logic req_error;
  logic same_req;
  logic access;
  logic [1:0] state_out;

  // Request decode
  always_comb begin
    req_any   = ramREN | ramWEN;
    req_both  = ramREN & ramWEN;
    aligned   = (ramaddr[1:0] == 2'b00);
    in_range  = ({2'b00, ramaddr[31:2]} < DEPTH);
    req_valid = req_any && !req_both && aligned && in_range;
    req_error = req_both || (req_any && (!aligned || !in_range));
    same_req  = (ramaddr[31:2] == addr_q) && (ramWEN == op_q);
    word_idx  = ramaddr[AW+1:2];
  end

  // Next-state and status
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    op_d      = op_q;
    state_out = FREE;
    access    = 1'b0;

    if (RST) begin
      state_out = FREE;
    end else if (req_error) begin
      state_out = ERROR;
      state_d   = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!req_valid) begin
            state_out = FREE;
          end else if (LAT == 0) begin
            state_out = ACCESS;
            access    = 1'b1;
          end else begin
            state_out = BUSY;
            addr_d    = ramaddr[31:2];
            op_d      = ramWEN;
            cnt_d     = LAT_M1;
            state_d   = WAIT;
          end
        end
        WAIT: begin
          if (!req_valid) begin
            // Requester withdrew: abort without touching memory.
            state_out = FREE;
            state_d   = IDLE;
          end else if (!same_req) begin
            state_out = BUSY;
            addr_d    = ramaddr[31:2];
            op_d      = ramWEN;
            cnt_d     = LAT_M1;
          end else if (cnt_q != 4'd0) begin
            state_out = BUSY;
            cnt_d     = cnt_q - 4'd1;
          end else begin
            state_out = ACCESS;
            access    = 1'b1;
            state_d   = IDLE;
          end
        end
        default: begin
          state_out = FREE;
          state_d   = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 30'd0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
    end
  end

  // Memory is deliberately outside reset; access is already gated by RST above.
  always_ff @(posedge CLK) begin
    if (access && ramWEN) begin
      mem[word_idx] <= ramstore;
    end
  end

  always_comb begin
    ramstate = state_out;
    ramload  = 32'd0;
    if (access && ramREN) begin
      ramload = mem[word_idx];
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: a LAT=2 instance and a LAT=0 instance, checked per cycle
// against a scoreboard queue and a small memory model.
module tb_ram_responder;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ren = 1'b0, wen = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [31:0] rdata;
  logic [1:0]  st;
  logic        ren0 = 1'b0, wen0 = 1'b0;
  logic [31:0] addr0 = 32'd0, wdata0 = 32'd0;
  logic [31:0] rdata0;
  logic [1:0]  st0;

  int compared = 0;
  int mismatched = 0;
  logic [33:0] exp_q[$];
  logic [31:0] model[int];
  logic [31:0] model0[int];

  ram_responder #(.LAT(2), .DEPTH(1024)) dut (
    .CLK(CLK), .RST(RST), .ramREN(ren), .ramWEN(wen), .ramaddr(addr),
    .ramstore(wdata), .ramload(rdata), .ramstate(st)
  );

  ram_responder #(.LAT(0), .DEPTH(1024)) dut0 (
    .CLK(CLK), .RST(RST), .ramREN(ren0), .ramWEN(wen0), .ramaddr(addr0),
    .ramstore(wdata0), .ramload(rdata0), .ramstate(st0)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] rd(input logic [31:0] a);
    return model[int'(a[31:2])];
  endfunction

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed state=%0d load=%h, expected state=%0d load=%h",
             tag, obs[33:32], obs[31:0], exp[33:32], exp[31:0]);
    end
  endtask

  // One cycle on the LAT=2 instance.
  task automatic cyc(input string tag, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [1:0] es, input logic [31:0] el);
    @(negedge CLK);
    ren = r; wen = w; addr = a; wdata = d;
    exp_q.push_back({es, el});
    #1;
    check(tag, {st, rdata}, exp_q.pop_front());
    if (es == ACCESS && w) model[int'(a[31:2])] = d;
  endtask

  // One cycle on the LAT=0 instance.
  task automatic cyc0(input string tag, input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [1:0] es, input logic [31:0] el);
    @(negedge CLK);
    ren0 = r; wen0 = w; addr0 = a; wdata0 = d;
    exp_q.push_back({es, el});
    #1;
    check(tag, {st0, rdata0}, exp_q.pop_front());
    if (es == ACCESS && w) model0[int'(a[31:2])] = d;
  endtask

  initial begin
    // Reset overrides a pending request
    RST = 1'b1;
    cyc("rst_req", 1, 0, 32'h40, 0, FREE, 0);
    cyc("rst_both", 1, 1, 32'h40, 0, FREE, 0);
    @(negedge CLK); RST = 1'b0; ren = 0; wen = 0;
    cyc("idle", 0, 0, 0, 0, FREE, 0);

    // Write then read back with two wait states
    cyc("wr40_b0", 0, 1, 32'h40, 32'hDEADBEEF, BUSY, 0);
    cyc("wr40_b1", 0, 1, 32'h40, 32'hDEADBEEF, BUSY, 0);
    cyc("wr40_acc", 0, 1, 32'h40, 32'hDEADBEEF, ACCESS, 0);
    cyc("rd40_b0", 1, 0, 32'h40, 0, BUSY, 0);
    cyc("rd40_b1", 1, 0, 32'h40, 0, BUSY, 0);
    cyc("rd40_acc", 1, 0, 32'h40, 0, ACCESS, 32'hDEADBEEF);

    // Aborted write leaves prior contents
    cyc("wr80_b0", 0, 1, 32'h80, 32'h12345678, BUSY, 0);
    cyc("wr80_b1", 0, 1, 32'h80, 32'h12345678, BUSY, 0);
    cyc("wr80_acc", 0, 1, 32'h80, 32'h12345678, ACCESS, 0);
    cyc("gap", 0, 0, 0, 0, FREE, 0);
    cyc("ab80_b0", 0, 1, 32'h80, 32'h1, BUSY, 0);
    cyc("ab80_free", 0, 0, 32'h80, 32'h1, FREE, 0);
    cyc("rd80_b0", 1, 0, 32'h80, 0, BUSY, 0);
    cyc("rd80_b1", 1, 0, 32'h80, 0, BUSY, 0);
    cyc("rd80_acc", 1, 0, 32'h80, 0, ACCESS, rd(32'h80));

    // Address change mid-wait restarts the count
    cyc("wr44_b0", 0, 1, 32'h44, 32'hCAFEF00D, BUSY, 0);
    cyc("wr44_b1", 0, 1, 32'h44, 32'hCAFEF00D, BUSY, 0);
    cyc("wr44_acc", 0, 1, 32'h44, 32'hCAFEF00D, ACCESS, 0);
    cyc("sw_c0", 1, 0, 32'h40, 0, BUSY, 0);
    cyc("sw_c1", 1, 0, 32'h44, 0, BUSY, 0);
    cyc("sw_c2", 1, 0, 32'h44, 0, BUSY, 0);
    cyc("sw_c3", 1, 0, 32'h44, 0, ACCESS, rd(32'h44));
    // Held read after ACCESS is a fresh transaction
    cyc("held_b0", 1, 0, 32'h44, 0, BUSY, 0);
    cyc("held_b1", 1, 0, 32'h44, 0, BUSY, 0);
    cyc("held_acc", 1, 0, 32'h44, 0, ACCESS, rd(32'h44));

    // Error cases, including one that interrupts a wait
    cyc("err_both", 1, 1, 32'h40, 32'h0, ERROR, 0);
    cyc("err_misal", 0, 1, 32'h42, 32'h0, ERROR, 0);
    cyc("err_range", 1, 0, 32'h1000, 0, ERROR, 0);
    cyc("err_rangew", 0, 1, 32'h1000, 32'h0, ERROR, 0);
    cyc("errw_b0", 0, 1, 32'h40, 32'h55, BUSY, 0);
    cyc("errw_both", 1, 1, 32'h40, 32'h55, ERROR, 0);
    cyc("errw_new", 0, 1, 32'h40, 32'h55, BUSY, 0);
    cyc("errw_drop", 0, 0, 0, 0, FREE, 0);
    cyc("chk40_b0", 1, 0, 32'h40, 0, BUSY, 0);
    cyc("chk40_b1", 1, 0, 32'h40, 0, BUSY, 0);
    cyc("chk40_acc", 1, 0, 32'h40, 0, ACCESS, rd(32'h40));
    cyc("chk0_b0", 1, 0, 32'h0, 0, BUSY, 0);
    cyc("chk0_b1", 1, 0, 32'h0, 0, BUSY, 0);

    // Reset during a write wait: no commit
    cyc("rw_b0", 0, 1, 32'h40, 32'hAAAA5555, BUSY, 0);
    @(negedge CLK); RST = 1'b1;
    exp_q.push_back({FREE, 32'd0});
    #1 check("rw_rst", {st, rdata}, exp_q.pop_front());
    @(negedge CLK); RST = 1'b0; wen = 0;
    exp_q.push_back({FREE, 32'd0});
    #1 check("rw_after", {st, rdata}, exp_q.pop_front());
    cyc("rw_rd_b0", 1, 0, 32'h40, 0, BUSY, 0);
    cyc("rw_rd_b1", 1, 0, 32'h40, 0, BUSY, 0);
    cyc("rw_rd_acc", 1, 0, 32'h40, 0, ACCESS, 32'hDEADBEEF);
    cyc("end2", 0, 0, 0, 0, FREE, 0);

    // Zero-latency instance: same-cycle access, read-after-write
    cyc0("l0_idle", 0, 0, 0, 0, FREE, 0);
    cyc0("l0_wr40", 0, 1, 32'h40, 32'h0BADCAFE, ACCESS, 0);
    cyc0("l0_rd40", 1, 0, 32'h40, 0, ACCESS, model0[16]);
    cyc0("l0_wr40b", 0, 1, 32'h40, 32'h600DF00D, ACCESS, 0);
    cyc0("l0_wr48", 0, 1, 32'h48, 32'h11223344, ACCESS, 0);
    cyc0("l0_rd40b", 1, 0, 32'h40, 0, ACCESS, model0[16]);
    cyc0("l0_err", 0, 1, 32'h41, 32'hFFFFFFFF, ERROR, 0);
    cyc0("l0_rd48", 1, 0, 32'h48, 0, ACCESS, model0[18]);
    cyc0("l0_free", 0, 0, 0, 0, FREE, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 The block SHALL have parameter LAT, default 2, meaning wait cycles before ACCESS, legal range 0..15.
REQ-002 The block SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words stored.
REQ-003 CLK  input  1  meaning the sole clock; all state updates on the rising edge.
REQ-004 RST  input  1  meaning reset, synchronous and active-high.
REQ-005 ramREN  input  1  meaning read request, level held by the requester until ACCESS.
REQ-006 ramWEN  input  1  meaning write request, level held by the requester until ACCESS.
REQ-007 ramaddr  input  32  meaning byte address; word index is ramaddr[31:2].
REQ-008 ramstore  input  32  meaning write data.
REQ-009 ramload  output  32  meaning read data, valid only while ramstate==ACCESS for a read.
REQ-010 ramstate  output  2  meaning ramstate_t encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Function
REQ-011 A request SHALL be valid when exactly one of ramREN/ramWEN is high, ramaddr[1:0]==0 and ramaddr[31:2]<DEPTH.
REQ-012 ramstate SHALL be ERROR, combinationally, whenever ramREN&ramWEN, or a request is present with a misaligned or out-of-range address.
REQ-013 In ERROR there SHALL be no memory access, the FSM SHALL go to or stay in IDLE, and ramload SHALL be 0.
REQ-014 The FSM SHALL have states IDLE and WAIT, plus a 4-bit counter cnt and latched registers for address and operation.
REQ-015 In IDLE with no request, ramstate SHALL be FREE and ramload 0.
REQ-016 In IDLE with a valid request and LAT==0, ramstate SHALL be ACCESS in that same cycle and the FSM SHALL stay in IDLE.
REQ-017 In IDLE with a valid request and LAT>0, ramstate SHALL be BUSY, the address and operation SHALL be latched, cnt SHALL load LAT-1 and the FSM SHALL go to WAIT.
REQ-018 In WAIT with the same valid request and cnt!=0, ramstate SHALL be BUSY and cnt SHALL decrement.
REQ-019 In WAIT with the same valid request and cnt==0, ramstate SHALL be ACCESS and the FSM SHALL return to IDLE.
REQ-020 An access SHALL take LAT BUSY cycles followed by one ACCESS cycle.
REQ-021 In WAIT with no request, ramstate SHALL be FREE, the operation SHALL be aborted with no write, and the FSM SHALL go to IDLE.
REQ-022 In WAIT with a valid request whose address or operation differs from the latched one, ramstate SHALL be BUSY, the new request SHALL be latched and cnt SHALL reload LAT-1 (restart).
REQ-023 A request still held after ACCESS SHALL be treated as a new transaction (BUSY again when LAT>0).
REQ-024 During a read ACCESS, ramload SHALL equal mem[ramaddr[31:2]] combinationally.
REQ-025 During a write ACCESS, mem[ramaddr[31:2]] SHALL take ramstore at the closing clock edge.
REQ-026 A write SHALL commit exactly once per ACCESS cycle and never in BUSY, FREE or ERROR.
REQ-027 A read in the cycle after a write ACCESS to the same word SHALL return the new data.

Reset
REQ-028 When RST is high at a clock edge, the FSM SHALL go to IDLE and cnt and the latched address and operation registers SHALL be cleared.
REQ-029 In any cycle in which RST is high, ramstate SHALL be FREE and ramload 0, regardless of ramREN/ramWEN.
REQ-030 Reset SHALL NOT alter memory contents; a WAIT in progress SHALL be aborted with no write.
REQ-031 Memory contents after power-up SHALL be undefined; benches SHALL write before reading.

Verification
REQ-032 LAT=2: hold WEN, addr 0x40, data 0xDEADBEEF -> BUSY, BUSY, ACCESS; then hold REN at 0x40 -> BUSY, BUSY, ACCESS with ramload=0xDEADBEEF.
REQ-033 LAT=2: WEN at 0x80 with data 0x1, dropped after one BUSY cycle -> FREE next cycle; a later read of 0x80 returns its prior value.
REQ-034 LAT=2: REN at 0x40, switched to 0x44 in cycle 1 -> BUSY in cycles 0-2, ACCESS in cycle 3 with ramload=mem[0x44>>2].
REQ-035 REN&WEN both high -> ERROR; WEN at 0x42 -> ERROR; REN at 0x1000 with DEPTH=1024 -> ERROR; memory unchanged in each case.
REQ-036 RST asserted during WAIT of a write -> FREE in the next cycle and no write committed; with LAT=0, REN at 0x40 -> ACCESS in the same cycle.
